// File: rtl/calc_pkg.sv
// Shared constants, types and the sequencer state encoding for the calc engine.
package calc_pkg;

    localparam int N_LANES = 40;
    localparam int BA      = 24;
    localparam int BB      = 16;
    localparam int AW_DEF  = 8;

    typedef logic [AW_DEF-1:0] addr_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/calc_delayline.sv
// Fixed-depth {valid, data} shift line matching the engine's lane-to-lane skew.
module calc_delayline #(
    parameter int DEPTH = 40,
    parameter int W     = 8,
    // any_valid ignores the last TAIL stages so the owner can look ahead.
    parameter int TAIL  = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         any_valid
);

    logic [DEPTH-1:0] valid_reg;
    logic [W-1:0]     data_reg [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        valid_reg[0] <= 1'b0;
                        data_reg[0]  <= '0;
                    end else begin
                        valid_reg[0] <= in_valid;
                        data_reg[0]  <= in_data;
                    end
                end
            end else begin : g_body
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        valid_reg[gi] <= 1'b0;
                        data_reg[gi]  <= '0;
                    end else begin
                        valid_reg[gi] <= valid_reg[gi-1];
                        data_reg[gi]  <= data_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign out_valid = valid_reg[DEPTH-1];
    assign out_data  = data_reg[DEPTH-1];
    assign any_valid = |valid_reg[DEPTH-1-TAIL:0];

endmodule

// File: rtl/calc_sequencer.sv
// Job-level controller for the calc engine: issues operand reads, tracks skew, strobes writes.
// Optional performance counters (cyc_cnt, hold_cnt) are built when CALC_SEQ_PERF_EN is defined.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int N  = N_LANES,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          start_mode,
    input  logic [AW-1:0] start_len,
    input  logic [AW-1:0] base_addr,
    input  logic          hold,
    output logic          busy,
    output logic          done,
    output logic          eng_mode,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [AW-1:0] issue_cnt
`ifdef CALC_SEQ_PERF_EN
    ,
    output logic [31:0]   cyc_cnt,
    output logic [31:0]   hold_cnt
`endif
);

    seq_state_t    state_reg;
    logic [AW-1:0] len_reg;
    logic [AW-1:0] base_reg;
    logic          line_busy;

    // Two-stage look-ahead: DONE is entered while the last write is one stage
    // from the output, so the registered done lands the cycle after that write.
    calc_delayline #(
        .DEPTH (N),
        .W     (AW),
        .TAIL  (2)
    ) u_skew (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_en),
        .in_data   (rd_addr),
        .out_valid (wr_en),
        .out_data  (wr_addr),
        .any_valid (line_busy)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            len_reg   <= '0;
            base_reg  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            eng_mode  <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            issue_cnt <= '0;
        end else begin
            rd_en <= 1'b0;
            done  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        eng_mode  <= start_mode;
                        len_reg   <= start_len;
                        base_reg  <= base_addr;
                        issue_cnt <= '0;
                        busy      <= 1'b1;
                        state_reg <= (start_len == '0) ? ST_DONE : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!hold) begin
                        rd_en     <= 1'b1;
                        rd_addr   <= base_reg + issue_cnt;
                        issue_cnt <= issue_cnt + AW'(1);
                        if (issue_cnt + AW'(1) == len_reg)
                            state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!rd_en && !line_busy)
                        state_reg <= ST_DONE;
                end
                ST_DONE: begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

`ifdef CALC_SEQ_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_cnt  <= '0;
            hold_cnt <= '0;
        end else if (state_reg == ST_IDLE && start) begin
            cyc_cnt  <= '0;
            hold_cnt <= '0;
        end else begin
            if (busy)
                cyc_cnt <= cyc_cnt + 32'd1;
            if (state_reg == ST_ISSUE && hold)
                hold_cnt <= hold_cnt + 32'd1;
        end
    end
`endif

endmodule
